// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control blocks: fetch FSM state encoding, fetch-latency limits
// and the default PC/memory/instruction widths.
package cpu_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned FETCH_WAIT_MIN = 1;
  localparam int unsigned FETCH_WAIT_MAX = 3;

  localparam logic [2:0] CLR   = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] CAP   = 3'd3;
  localparam logic [2:0] VALID = 3'd4;
  localparam logic [2:0] JUMP  = 3'd5;
  localparam logic [2:0] HALT  = 3'd6;

  typedef enum logic [2:0] {
    StClr   = CLR,
    StAddr  = ADDR,
    StWait  = WAIT,
    StCap   = CAP,
    StValid = VALID,
    StJump  = JUMP,
    StHalt  = HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// Loadable 2-bit down-counter that times the program-memory read latency.
module fetch_wait_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [1:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 2'd0)) begin
      count_d = count_q - 2'd1;
    end
  end

  // Flags the edge at which the count lands on zero, so the FSM can move on that same edge.
  assign zero_o = (count_d == 2'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the PC counter chain and program memory, and hands each
// fetched byte to the decoder over a valid/ready handshake with jump and halt servicing.
module fetch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FETCH_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_q,
  input  logic              pc_carry,
  output logic              pc_en,
  output logic              pc_load_n,
  output logic              pc_clear_n,
  output logic [ADDR_W-1:0] pc_d,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              halt_req,
  output logic              halted,
  output logic              pc_wrapped
);

  if (FETCH_WAIT < FETCH_WAIT_MIN || FETCH_WAIT > FETCH_WAIT_MAX) begin : gen_fetch_wait_check
    $error("fetch_sequencer: FETCH_WAIT must be within 1..3");
  end

  localparam logic [1:0] WaitLoad = 2'(FETCH_WAIT - 1);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] jmp_pc_q, jmp_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrapped_q, wrapped_d;
  logic              timer_load, timer_dec, timer_zero;

  fetch_wait_timer u_wait_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (timer_load),
    .load_val_i (WaitLoad),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    jmp_pc_d    = jmp_pc_q;
    addr_d      = addr_q;
    wrapped_d   = wrapped_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    pc_en       = 1'b0;
    pc_load_n   = 1'b1;
    pc_clear_n  = 1'b1;
    mem_rd      = 1'b0;
    mem_addr    = addr_q;
    instr_valid = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      StClr: begin
        pc_clear_n = 1'b0;
        state_d    = StAddr;
      end
      StAddr: begin
        mem_rd     = 1'b1;
        mem_addr   = pc_q;
        addr_d     = pc_q;
        timer_load = 1'b1;
        state_d    = timer_zero ? StCap : StWait;
      end
      StWait: begin
        timer_dec = 1'b1;
        if (timer_zero) begin
          state_d = StCap;
        end
      end
      StCap: begin
        ir_d  = mem_rdata;
        pc_en = 1'b1;
        if (pc_carry) begin
          wrapped_d = 1'b1;
        end
        state_d = StValid;
      end
      StValid: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          if (halt_req) begin
            state_d = StHalt;
          end else if (jmp_req) begin
            jmp_pc_d = jmp_target;
            state_d  = StJump;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StJump: begin
        pc_load_n = 1'b0;
        state_d   = StAddr;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StClr;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StClr;
      ir_q      <= '0;
      jmp_pc_q  <= '0;
      addr_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      jmp_pc_q  <= jmp_pc_d;
      addr_q    <= addr_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign ir         = ir_q;
  assign pc_d       = jmp_pc_q;
  assign pc_wrapped = wrapped_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (FETCH_WAIT=1 and 3) sharing the decoder-side inputs,
// each with its own counter chain and a common program memory.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       instr_ready = 1'b0;
  logic       jmp_req = 1'b0;
  logic       halt_req = 1'b0;
  logic [7:0] jmp_target = 8'h00;

  logic [7:0] pc        [2];
  logic       pc_carry  [2];
  logic       pc_en     [2];
  logic       pc_load_n [2];
  logic       pc_clear_n[2];
  logic [7:0] pc_d      [2];
  logic       mem_rd    [2];
  logic [7:0] mem_addr  [2];
  logic [7:0] mem_rdata [2];
  logic [7:0] ir        [2];
  logic       instr_valid[2];
  logic       halted    [2];
  logic       pc_wrapped[2];
  logic [7:0] mem       [256];

  fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .FETCH_WAIT(1)) u_dut_fw1 (
    .clk(clk), .rst_n(rst_n), .pc_q(pc[0]), .pc_carry(pc_carry[0]), .pc_en(pc_en[0]),
    .pc_load_n(pc_load_n[0]), .pc_clear_n(pc_clear_n[0]), .pc_d(pc_d[0]), .mem_rd(mem_rd[0]),
    .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]), .ir(ir[0]), .instr_valid(instr_valid[0]),
    .instr_ready(instr_ready), .jmp_req(jmp_req), .jmp_target(jmp_target),
    .halt_req(halt_req), .halted(halted[0]), .pc_wrapped(pc_wrapped[0])
  );

  fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .FETCH_WAIT(3)) u_dut_fw3 (
    .clk(clk), .rst_n(rst_n), .pc_q(pc[1]), .pc_carry(pc_carry[1]), .pc_en(pc_en[1]),
    .pc_load_n(pc_load_n[1]), .pc_clear_n(pc_clear_n[1]), .pc_d(pc_d[1]), .mem_rd(mem_rd[1]),
    .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]), .ir(ir[1]), .instr_valid(instr_valid[1]),
    .instr_ready(instr_ready), .jmp_req(jmp_req), .jmp_target(jmp_target),
    .halt_req(halt_req), .halted(halted[1]), .pc_wrapped(pc_wrapped[1])
  );

  // Cascaded-counter chain: clear beats load beats count enable.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!pc_clear_n[k]) pc[k] <= 8'h00;
      else if (!pc_load_n[k]) pc[k] <= pc_d[k];
      else if (pc_en[k]) pc[k] <= pc[k] + 8'd1;
    end
  end

  assign pc_carry[0]  = pc_en[0] && (pc[0] == 8'hFF);
  assign pc_carry[1]  = pc_en[1] && (pc[1] == 8'hFF);
  assign mem_rdata[0] = mem[mem_addr[0]];
  assign mem_rdata[1] = mem[mem_addr[1]];

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic j, input logic h,
                       input logic [7:0] t);
    rst_n = r; instr_ready = rdy; jmp_req = j; halt_req = h; jmp_target = t;
  endtask

  task automatic step(input logic r, input logic rdy, input logic j, input logic h,
                      input logic [7:0] t);
    @(posedge clk);
    #1;
    drive(r, rdy, j, h, t);
    @(negedge clk);
  endtask

  task automatic wait_valid1(input int budget);
    for (int n = 0; n < budget && !instr_valid[1]; n++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_valid_timeout", instr_valid[1], 1'b1);
  endtask

  // {clear_n, rd, en, load_n, valid, halted, wrapped, ir, pc_d, mem_addr}
  function automatic logic [30:0] act_vec(input int k, input bit use_pcd, input bit use_addr);
    return {pc_clear_n[k], mem_rd[k], pc_en[k], pc_load_n[k], instr_valid[k], halted[k],
            pc_wrapped[k], ir[k], use_pcd ? pc_d[k] : 8'h00, use_addr ? mem_addr[k] : 8'h00};
  endfunction

  typedef struct {
    logic       rst_n;
    logic       rdy;
    logic       jmp;
    logic [7:0] tgt;
    byte        st;   // C=clear A=addr P=capture V=valid J=jump
    logic [7:0] val;  // mem_addr in A/P, pc_d in J/C
    logic [7:0] irv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic rdy, input logic j, input logic [7:0] t,
                              input byte st, input logic [7:0] val, input logic [7:0] irv);
    vec_t v;
    v.rst_n = r; v.rdy = rdy; v.jmp = j; v.tgt = t; v.st = st; v.val = val; v.irv = irv;
    return v;
  endfunction

  // Reference model: each fetch is a phase count since its address cycle, plus jump/halt/clear.
  bit         m_clr [2];
  bit         m_halt[2];
  bit         m_jump[2];
  bit         m_wrap[2];
  int         m_ph  [2];
  logic [7:0] m_pc  [2];
  logic [7:0] m_addr[2];
  logic [7:0] m_ir  [2];
  logic [7:0] m_pcd [2];

  task automatic model_step(input int k);
    int fw;
    fw = (k == 0) ? 1 : 3;
    if (!rst_n) begin
      m_clr[k] = 1; m_halt[k] = 0; m_jump[k] = 0; m_wrap[k] = 0; m_ph[k] = 0;
      m_pc[k] = 8'h00; m_addr[k] = 8'h00; m_ir[k] = 8'h00; m_pcd[k] = 8'h00;
    end else if (m_clr[k]) begin
      m_clr[k] = 0; m_ph[k] = 0;
    end else if (m_halt[k]) begin
      m_halt[k] = 1;
    end else if (m_jump[k]) begin
      m_jump[k] = 0; m_pc[k] = m_pcd[k]; m_ph[k] = 0;
    end else if (m_ph[k] == 0) begin
      m_addr[k] = m_pc[k]; m_ph[k] = 1;
    end else if (m_ph[k] < fw) begin
      m_ph[k]++;
    end else if (m_ph[k] == fw) begin
      m_ir[k] = mem[m_addr[k]];
      if (m_pc[k] == 8'hFF) m_wrap[k] = 1;
      m_pc[k] = m_pc[k] + 8'd1;
      m_ph[k]++;
    end else if (instr_ready) begin
      if (halt_req) m_halt[k] = 1;
      else if (jmp_req) begin m_pcd[k] = jmp_target; m_jump[k] = 1; end
      else m_ph[k] = 0;
    end
  endtask

  task automatic model_check(input int k, input int cyc);
    int fw;
    bit fetch, use_addr;
    logic [7:0] ea;
    logic [30:0] e;
    fw       = (k == 0) ? 1 : 3;
    fetch    = !m_clr[k] && !m_halt[k] && !m_jump[k];
    use_addr = fetch && (m_ph[k] <= fw);
    ea       = (m_ph[k] == 0) ? m_pc[k] : m_addr[k];
    e = {!m_clr[k], fetch && (m_ph[k] == 0), fetch && (m_ph[k] == fw), !m_jump[k],
         fetch && (m_ph[k] == fw + 1), m_halt[k], m_wrap[k], m_ir[k], m_pcd[k],
         use_addr ? ea : 8'h00};
    chk($sformatf("rand_fw%0d_cyc%0d", fw, cyc), act_vec(k, 1'b1, use_addr), e);
  endtask

  initial begin
    byte st;
    bit  use_addr, use_pcd;
    logic [30:0] e;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
    mem[8'h40] = 8'h5A; mem[8'hFF] = 8'hE7;

    // FETCH_WAIT=1: reset, sequential fetch, backpressure with ignored jump, taken jump.
    tbl.push_back(mk(0, 1, 0, 8'h00, "C", 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, "C", 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, "C", 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, 0, 8'h00, "C", 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, 0, 8'h00, "A", 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, 0, 8'h00, "P", 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, 0, 8'h00, "V", 8'h00, 8'hA1));
    tbl.push_back(mk(1, 1, 0, 8'h00, "A", 8'h01, 8'hA1));
    tbl.push_back(mk(1, 1, 0, 8'h00, "P", 8'h01, 8'hA1));
    tbl.push_back(mk(1, 1, 0, 8'h00, "V", 8'h00, 8'hB2));
    tbl.push_back(mk(1, 1, 0, 8'h00, "A", 8'h02, 8'hB2));
    tbl.push_back(mk(1, 1, 0, 8'h00, "P", 8'h02, 8'hB2));
    tbl.push_back(mk(1, 0, 0, 8'h00, "V", 8'h00, 8'hC3));
    tbl.push_back(mk(1, 0, 0, 8'h00, "V", 8'h00, 8'hC3));
    tbl.push_back(mk(1, 0, 1, 8'h77, "V", 8'h00, 8'hC3));
    tbl.push_back(mk(1, 0, 0, 8'h00, "V", 8'h00, 8'hC3));
    tbl.push_back(mk(1, 0, 0, 8'h00, "V", 8'h00, 8'hC3));
    tbl.push_back(mk(1, 1, 0, 8'h00, "V", 8'h00, 8'hC3));
    tbl.push_back(mk(1, 1, 0, 8'h00, "A", 8'h03, 8'hC3));
    tbl.push_back(mk(1, 1, 0, 8'h00, "P", 8'h03, 8'hC3));
    tbl.push_back(mk(1, 1, 1, 8'h40, "V", 8'h00, 8'hD4));
    tbl.push_back(mk(1, 1, 0, 8'h00, "J", 8'h40, 8'hD4));
    tbl.push_back(mk(1, 1, 0, 8'h00, "A", 8'h40, 8'hD4));
    tbl.push_back(mk(1, 1, 0, 8'h00, "P", 8'h40, 8'hD4));
    tbl.push_back(mk(1, 1, 0, 8'h00, "V", 8'h00, 8'h5A));
    tbl.push_back(mk(1, 1, 0, 8'h00, "A", 8'h41, 8'h5A));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      if (!tbl[i].rst_n) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      else drive(1'b1, tbl[i].rdy, tbl[i].jmp, 1'b0, tbl[i].tgt);
      @(negedge clk);
      st       = tbl[i].st;
      use_addr = (st == "A") || (st == "P");
      use_pcd  = (st == "J") || (st == "C");
      e = {st != "C", st == "A", st == "P", st != "J", st == "V", 1'b0, 1'b0, tbl[i].irv,
           use_pcd ? tbl[i].val : 8'h00, use_addr ? tbl[i].val : 8'h00};
      chk($sformatf("vec%0d", i), act_vec(0, use_pcd, use_addr), e);
    end

    // FETCH_WAIT=3: jump to 0xFF, wrap on capture, then halt beats a simultaneous jump.
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_post_release_clear_n", pc_clear_n[1], 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_first_addr", {mem_rd[1], mem_addr[1]}, {1'b1, 8'h00});
    wait_valid1(10);
    chk("fw3_ir0", ir[1], 8'hA1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_jump", {pc_load_n[1], pc_d[1]}, {1'b0, 8'hFF});
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_addr_ff", {mem_rd[1], mem_addr[1]}, {1'b1, 8'hFF});
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_wait1", {mem_rd[1], pc_en[1]}, 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_wait2", {mem_rd[1], pc_en[1], mem_addr[1]}, {2'b00, 8'hFF});
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_cap", {pc_en[1], pc_wrapped[1]}, 2'b10);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_wrap_valid", {pc_wrapped[1], instr_valid[1], ir[1], pc[1]}, {2'b11, 8'hE7, 8'h00});
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_halt", {halted[1], instr_valid[1], pc_load_n[1]}, 3'b101);
    for (int n = 0; n < 5; n++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      chk($sformatf("fw3_halted_%0d", n),
          {mem_rd[1], pc_en[1], pc_load_n[1], halted[1], pc_wrapped[1]}, 5'b00111);
    end

    // FETCH_WAIT=3: reset landing in the middle of a fetch.
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_valid1(10);
    chk("fw3_refetch_ir", ir[1], 8'hA1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_in_wait", {mem_rd[1], instr_valid[1]}, 2'b00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fw3_midfetch_reset", {pc_clear_n[1], instr_valid[1], ir[1], pc_wrapped[1]}, 11'd0);

    // Randomized run on both instances against the model.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      drive(1'($urandom_range(0, 99) >= 2), 1'($urandom_range(0, 99) < 60),
            1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 3), 8'($urandom));
      @(negedge clk);
      model_check(0, cyc);
      model_check(1, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
